// File: rtl/dp_ram_streamer.sv
// dp_ram_streamer: reads a block of bytes from the dual-port RAM, starting at
// a given address and wrapping modulo the RAM depth, and presents them as a
// valid/ready byte stream with a last-byte marker. A small output FIFO hides
// the RAM's one-cycle registered read latency.
module dp_ram_streamer #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int FIFO_D = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  localparam int LW = ADDR_W + 1;
  localparam int CW = $clog2(FIFO_D + 1);
  localparam int PW = $clog2(FIFO_D);
  localparam int OW = CW + 2;
  localparam logic [LW-1:0] DEPTH = LW'(1 << ADDR_W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr;
  logic [LW-1:0]     len, issued, sent, len_c;
  logic              pend;
  logic [DATA_W-1:0] fifo_mem [FIFO_D];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_count;
  logic              push, pop, last_byte, issue_ok, launch;
  logic [OW-1:0]     occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_D - 1)) ? '0 : p + 1'b1;
  endfunction

  // Command decode, handshake and read-issue throttling.
  // occ counts bytes in the FIFO, on the RAM output, and being read; a pop at
  // this edge frees a slot, which is what allows one byte per cycle at depth 3.
  always_comb begin
    len_c     = (length > DEPTH) ? DEPTH : length;
    launch    = (state == IDLE) && start && (len_c != '0);
    push      = pend;
    pop       = m_valid & m_ready;
    last_byte = (sent == len - 1'b1);
    occ       = OW'(fifo_count) + OW'(pend) + OW'(ram_rd);
    issue_ok  = (state == RUN) && (issued < len) &&
                (occ < (OW'(FIFO_D) + OW'(pop)));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = (len_c == '0) ? DONE : RUN;
      RUN:  if (pop && last_byte) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status and stream outputs.
  always_comb begin
    busy    = (state == RUN);
    done    = (state == DONE);
    ram_en  = busy | ram_rd;
    m_valid = (fifo_count != '0);
    m_data  = m_valid ? fifo_mem[rd_ptr] : '0;
    m_last  = m_valid & last_byte;
  end

  // Read issue, counters and FIFO pointers; the first read goes out on the
  // start edge itself so ram_rd is already high in the first busy cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr        <= '0;
      len         <= '0;
      issued      <= '0;
      sent        <= '0;
      ram_rd      <= 1'b0;
      ram_rd_addr <= '0;
      pend        <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
    end else begin
      ram_rd <= 1'b0;
      if (launch) begin
        ram_rd      <= 1'b1;
        ram_rd_addr <= start_addr;
        addr        <= start_addr + 1'b1;
        len         <= len_c;
        issued      <= LW'(1);
        sent        <= '0;
      end else if (issue_ok) begin
        ram_rd      <= 1'b1;
        ram_rd_addr <= addr;
        addr        <= addr + 1'b1;
        issued      <= issued + 1'b1;
      end
      pend <= ram_rd;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
        sent   <= sent + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ram_rd_data;
  end

endmodule

// File: tb/tb_dp_ram_streamer.sv
// Scoreboard bench for dp_ram_streamer with a behavioural 64x8 RAM (mem[i]=i).
module tb_dp_ram_streamer;

  logic       clk = 1'b0;
  logic       rst, start, busy, done, ram_en, ram_rd;
  logic [5:0] start_addr, ram_rd_addr;
  logic [6:0] length;
  logic [7:0] ram_rd_data, m_data;
  logic       m_valid, m_ready, m_last;

  always #5 clk = ~clk;

  dp_ram_streamer #(.ADDR_W(6), .DATA_W(8), .FIFO_D(3)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .length(length), .busy(busy), .done(done), .ram_en(ram_en),
    .ram_rd(ram_rd), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  logic [7:0] mem [64];
  initial for (int i = 0; i < 64; i++) mem[i] = 8'(i);
  initial ram_rd_data = '0;
  always @(posedge clk) if (ram_en && ram_rd) ram_rd_data <= mem[ram_rd_addr];

  typedef struct { logic [7:0] d; logic l; } exp_t;
  exp_t dq[$];
  int   aq[$];
  int   checks = 0, failures = 0;
  int   outst = 0, done_cnt = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic rand_ready = 1'b0;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_xfer(input int a, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.d = 8'((a + i) % 64);
      e.l = (i == n - 1);
      dq.push_back(e);
      aq.push_back((a + i) % 64);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ram_en"}, ram_en, 0);
    chk({tag, "_ram_rd"}, ram_rd, 0);
    chk({tag, "_ram_rd_addr"}, ram_rd_addr, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_last"}, m_last, 0);
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k = 0;
    while (!done && k < limit) begin
      cyc();
      k++;
    end
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_busy_at_done"}, busy, 0);
    cyc();
    chk({tag, "_bytes_left"}, dq.size(), 0);
    chk({tag, "_reads_left"}, aq.size(), 0);
  endtask

  task automatic issue(input int a, input int n);
    start = 1'b1;
    start_addr = 6'(a);
    length = 7'(n);
    cyc();
    start = 1'b0;
  endtask

  // Pseudo-random backpressure driver.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: read addresses, stream bytes, stall stability and occupancy.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rst) begin
      dq.delete();
      aq.delete();
      outst = 0;
      prev_stall = 1'b0;
    end else begin
      if (ram_rd) begin
        if (aq.size() == 0) chk("unexpected_rd", 1, 0);
        else chk("rd_addr", ram_rd_addr, aq.pop_front());
        outst++;
      end
      if (ram_rd || m_valid) chk("occupancy_le_3", int'(outst <= 3), 1);
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        if (dq.size() == 0) chk("unexpected_byte", 1, 0);
        else begin
          exp_t e;
          e = dq.pop_front();
          chk("byte_data", m_data, e.d);
          chk("byte_last", m_last, e.l);
        end
        outst--;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; start_addr = '0; length = '0; m_ready = 1'b1;
    cyc();
    chk_reset_outputs("reset");
    cyc();
    rst = 1'b0;
    cyc();

    // Basic: addr 5, 4 bytes, exact cycle timing.
    push_xfer(5, 4);
    issue(5, 4);                       // now in cycle 1
    chk("t1_busy_c1", busy, 1);
    chk("t1_ram_rd_c1", ram_rd, 1);
    chk("t1_addr_c1", ram_rd_addr, 5);
    cyc(); cyc();                      // cycle 3
    chk("t1_valid_c3", m_valid, 1);
    chk("t1_data_c3", m_data, 5);
    chk("t1_last_c3", m_last, 0);
    cyc(); cyc(); cyc();               // cycle 6
    chk("t1_last_c6", m_last, 1);
    chk("t1_data_c6", m_data, 8);
    cyc();                             // cycle 7
    chk("t1_done_c7", done, 1);
    chk("t1_busy_c7", busy, 0);
    cyc();
    chk("t1_done_c8", done, 0);
    chk("t1_bytes_left", dq.size(), 0);

    // Address wrap 62,63,0,1.
    push_xfer(62, 4);
    issue(62, 4);
    wait_done("t2", 50);

    // Empty transfer.
    d0 = done_cnt;
    issue(9, 0);
    chk("t3_done_c1", done, 1);
    chk("t3_busy_c1", busy, 0);
    chk("t3_ram_rd_c1", ram_rd, 0);
    chk("t3_valid_c1", m_valid, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t3_busy_after", busy, 0);
      chk("t3_done_after", done, 0);
    end

    // Full block under random backpressure.
    push_xfer(10, 64);
    rand_ready = 1'b1;
    issue(10, 64);
    wait_done("t4", 600);
    rand_ready = 1'b0;
    cyc();
    m_ready = 1'b1;
    cyc();

    // Length clamp 70 -> 64.
    push_xfer(0, 64);
    issue(0, 70);
    wait_done("t5", 200);

    // Reset in cycle 5 of a 20-byte transfer.
    push_xfer(0, 20);
    issue(0, 20);                      // cycle 1
    cyc(); cyc(); cyc(); cyc();        // cycle 5
    rst = 1'b1;
    cyc();                             // cycle 6
    chk_reset_outputs("t6_rst");
    rst = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t6_idle_busy", busy, 0);
      chk("t6_idle_valid", m_valid, 0);
    end
    chk("t6_no_done", done_cnt - d0, 0);
    push_xfer(30, 5);
    issue(30, 5);
    wait_done("t6_fresh", 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
